// File: rtl/timer_pkg.sv
// Shared types for the loadable down-counter/timer.
package timer_pkg;

    localparam int TIMER_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a programmed value to zero, pulses on
// terminal count, optionally reloads for periodic ticks.
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             start,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    assign load_ready = (state_q != RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign count      = count_q;
    assign tc_pulse   = tc_q;

    // Priority: abort > load handshake > start > count/terminal.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load_valid && load_ready) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = ARMED;
        end else begin
            unique case (state_q)
                ARMED: if (start) begin
                    if (count_q != '0) state_d = RUN;
                    else begin
                        state_d = DONE;
                        tc_d    = 1'b1;
                    end
                end
                DONE: if (start) begin
                    count_d = reload_q;
                    if (reload_q != '0) state_d = RUN;
                    else                tc_d    = 1'b1;
                end
                RUN: if (enable) begin
                    if (count_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (auto_reload) count_d = reload_q;
                        else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end else if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

endmodule
